// File: rtl/wb_pkg.sv
// Shared register-file write-back types and sizes.
package wb_pkg;

    localparam int REG_W  = 16;
    localparam int REG_AW = 3;
    localparam int NREGS  = 8;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [REG_W-1:0]  data;
    } wb_req_t;

    // One-hot decode of a register number into a per-register strobe vector.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] n);
        reg_onehot = NREGS'(1) << n;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick2.sv
// Two-grant round-robin picker: grant A is the first full slot at or after
// rr_ptr; grant B is the next full slot after A whose destination differs
// from A's, so the two register-file write ports never collide.
module rr_pick2
    import wb_pkg::*;
#(
    parameter  int NSRC = 4,
    localparam int PW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]        full,
    input  logic [NSRC*REG_AW-1:0] dest,
    input  logic [PW-1:0]          rr_ptr,
    output logic                   a_valid,
    output logic [PW-1:0]          a_idx,
    output logic                   b_valid,
    output logic [PW-1:0]          b_idx
);

    logic [REG_AW-1:0] a_dest;
    int                idx;

    // Walk the slots in round-robin order once, taking A then the first non-colliding B.
    always_comb begin
        a_valid = 1'b0;
        a_idx   = '0;
        b_valid = 1'b0;
        b_idx   = '0;
        a_dest  = '0;
        idx     = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (full[idx]) begin
                if (!a_valid) begin
                    a_valid = 1'b1;
                    a_idx   = PW'(idx);
                    a_dest  = dest[idx*REG_AW +: REG_AW];
                end else if (!b_valid && (dest[idx*REG_AW +: REG_AW] != a_dest)) begin
                    b_valid = 1'b1;
                    b_idx   = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one single-entry slot per result source, drained onto
// two register-file write ports per cycle with round-robin fairness.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        src_valid,
    output logic [NSRC-1:0]        src_ready,
    input  logic [NSRC*REG_AW-1:0] src_dest,
    input  logic [NSRC*REG_W-1:0]  src_data,
    output logic                   write0,
    output logic [REG_AW-1:0]      num_write0_out,
    output logic [REG_W-1:0]       data_write0_out,
    output logic                   write1,
    output logic [REG_AW-1:0]      num_write1_out,
    output logic [REG_W-1:0]       data_write1_out,
    output logic [NREGS-1:0]       wr_done
);

    localparam int PW = $clog2(NSRC);

    logic [NSRC-1:0]        full_q;
    wb_req_t                slot_q [NSRC];
    logic [PW-1:0]          rr_ptr_q;
    logic [PW-1:0]          rr_ptr_nxt;
    logic [NSRC*REG_AW-1:0] dest_vec;
    logic                   a_valid;
    logic                   b_valid;
    logic [PW-1:0]          a_idx;
    logic [PW-1:0]          b_idx;
    logic [PW-1:0]          last_idx;
    logic [NSRC-1:0]        granted;
    logic [NSRC-1:0]        accept;

    // Flatten slot destinations for the picker.
    always_comb begin
        dest_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            dest_vec[i*REG_AW +: REG_AW] = slot_q[i].dest;
        end
    end

    rr_pick2 #(.NSRC(NSRC)) u_pick (
        .full    (full_q),
        .dest    (dest_vec),
        .rr_ptr  (rr_ptr_q),
        .a_valid (a_valid),
        .a_idx   (a_idx),
        .b_valid (b_valid),
        .b_idx   (b_idx)
    );

    // Granted mask; a slot being drained this cycle can take a new result at the same edge.
    always_comb begin
        granted = '0;
        if (a_valid) granted[a_idx] = 1'b1;
        if (b_valid) granted[b_idx] = 1'b1;
    end

    assign src_ready = ~full_q | granted;
    assign accept    = src_valid & src_ready;

    // Write ports; forced idle during reset and zeroed when not writing.
    always_comb begin
        write0          = a_valid & ~rst;
        write1          = b_valid & ~rst;
        num_write0_out  = write0 ? slot_q[a_idx].dest : '0;
        data_write0_out = write0 ? slot_q[a_idx].data : '0;
        num_write1_out  = write1 ? slot_q[b_idx].dest : '0;
        data_write1_out = write1 ? slot_q[b_idx].data : '0;
    end

    // Pointer moves just past the later of the two grants, holding when idle.
    always_comb begin
        last_idx   = b_valid ? b_idx : a_idx;
        rr_ptr_nxt = rr_ptr_q;
        if (a_valid) begin
            rr_ptr_nxt = (last_idx == PW'(NSRC-1)) ? '0 : last_idx + 1'b1;
        end
    end

    // Slot occupancy, round-robin pointer and write-completion strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= '0;
            rr_ptr_q <= '0;
            wr_done  <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (accept[i]) begin
                    full_q[i] <= 1'b1;
                end else if (granted[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
            rr_ptr_q <= rr_ptr_nxt;
            wr_done  <= (write0 ? reg_onehot(num_write0_out) : '0)
                      | (write1 ? reg_onehot(num_write1_out) : '0);
        end
    end

    // Slot payload capture; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (accept[i]) begin
                slot_q[i].dest <= src_dest[i*REG_AW +: REG_AW];
                slot_q[i].data <= src_data[i*REG_W +: REG_W];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a cycle model of the slot/grant rules checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  src_valid = '0;
    logic [N-1:0]  src_ready;
    logic [N*3-1:0]  src_dest = '0;
    logic [N*16-1:0] src_data = '0;
    logic          write0, write1;
    logic [2:0]    num_write0_out, num_write1_out;
    logic [15:0]   data_write0_out, data_write1_out;
    logic [7:0]    wr_done;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.NSRC(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .src_dest        (src_dest),
        .src_data        (src_data),
        .write0          (write0),
        .num_write0_out  (num_write0_out),
        .data_write0_out (data_write0_out),
        .write1          (write1),
        .num_write1_out  (num_write1_out),
        .data_write1_out (data_write1_out),
        .wr_done         (wr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_full [N];
    logic [2:0]  m_dest [N];
    logic [15:0] m_data [N];
    int          m_ptr;
    logic [7:0]  m_done;
    logic [7:0]  m_done_nxt;
    logic [N-1:0] m_ready;
    int          g_a, g_b;

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_ptr  = 0;
        m_done = '0;
    endtask

    task automatic model_pick();
        int order[$];
        g_a = -1;
        g_b = -1;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) begin
            if (m_full[order[j]]) begin
                if (g_a < 0) g_a = order[j];
                else if (g_b < 0 && m_dest[order[j]] != m_dest[g_a]) g_b = order[j];
            end
        end
        for (int i = 0; i < N; i++) m_ready[i] = !m_full[i] || i == g_a || i == g_b;
        m_done_nxt = '0;
        if (g_a >= 0) m_done_nxt[m_dest[g_a]] = 1'b1;
        if (g_b >= 0) m_done_nxt[m_dest[g_b]] = 1'b1;
    endtask

    task automatic model_step();
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && m_ready[i]) begin
                    m_full[i] = 1'b1;
                    m_dest[i] = src_dest[i*3 +: 3];
                    m_data[i] = src_data[i*16 +: 16];
                end else if (i == g_a || i == g_b) begin
                    m_full[i] = 1'b0;
                end
            end
            if (g_b >= 0)      m_ptr = (g_b + 1) % N;
            else if (g_a >= 0) m_ptr = (g_a + 1) % N;
            m_done = m_done_nxt;
        end
    endtask

    // Compare process: outputs against the model at every falling edge.
    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (rst) model_clear();
            model_pick();
            chk("m_write0", 32'(write0), 32'(g_a >= 0));
            chk("m_num0",   32'(num_write0_out),  (g_a >= 0) ? 32'(m_dest[g_a]) : 32'd0);
            chk("m_data0",  32'(data_write0_out), (g_a >= 0) ? 32'(m_data[g_a]) : 32'd0);
            chk("m_write1", 32'(write1), 32'(g_b >= 0));
            chk("m_num1",   32'(num_write1_out),  (g_b >= 0) ? 32'(m_dest[g_b]) : 32'd0);
            chk("m_data1",  32'(data_write1_out), (g_b >= 0) ? 32'(m_data[g_b]) : 32'd0);
            chk("m_ready",  32'(src_ready), 32'(m_ready));
            chk("m_wr_done", 32'(wr_done), 32'(m_done));
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [2:0] d, input logic [15:0] v);
        src_valid[i]       = 1'b1;
        src_dest[i*3 +: 3]  = d;
        src_data[i*16 +: 16] = v;
    endtask

    task automatic do_reset();
        src_valid = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int dbl;
    int gcnt [N];
    int stale;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready",   32'(src_ready), 32'hF);
        chk("reset_wr_done", 32'(wr_done), 32'h0);
        chk("reset_write0",  32'(write0), 32'h0);

        // single result
        tick();
        set_src(0, 3'd3, 16'hBEEF);
        tick();
        src_valid = '0;
        @(negedge clk);
        chk("single_write0", 32'(write0), 32'h1);
        chk("single_num0",   32'(num_write0_out), 32'h3);
        chk("single_data0",  32'(data_write0_out), 32'hBEEF);
        chk("single_write1", 32'(write1), 32'h0);
        tick();
        @(negedge clk);
        chk("single_wr_done", 32'(wr_done), 32'h08);

        // dual write, distinct dests
        do_reset();
        set_src(0, 3'd1, 16'h1111);
        set_src(1, 3'd2, 16'h2222);
        tick();
        src_valid = '0;
        @(negedge clk);
        chk("dual_write0", 32'(write0), 32'h1);
        chk("dual_num0",   32'(num_write0_out), 32'h1);
        chk("dual_write1", 32'(write1), 32'h1);
        chk("dual_num1",   32'(num_write1_out), 32'h2);
        tick();
        @(negedge clk);
        chk("dual_wr_done", 32'(wr_done), 32'h06);

        // same-dest collision
        do_reset();
        set_src(0, 3'd5, 16'hA0A0);
        set_src(1, 3'd5, 16'hB1B1);
        tick();
        src_valid = '0;
        @(negedge clk);
        chk("coll_c1_num0",  32'(num_write0_out), 32'h5);
        chk("coll_c1_data0", 32'(data_write0_out), 32'hA0A0);
        chk("coll_c1_write1", 32'(write1), 32'h0);
        tick();
        @(negedge clk);
        chk("coll_c2_write0", 32'(write0), 32'h1);
        chk("coll_c2_data0",  32'(data_write0_out), 32'hB1B1);
        chk("coll_c2_write1", 32'(write1), 32'h0);
        tick();
        @(negedge clk);
        chk("coll_wr_done", 32'(wr_done), 32'h20);
        chk("coll_idle",    32'(write0), 32'h0);

        // all sources streaming, distinct dests
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 3'(i), 16'(i << 12));
        dbl = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            for (int i = 0; i < N; i++) src_data[i*16 +: 16] = 16'((i << 12) | (c + 1));
            @(negedge clk);
            if (write0 && write1) dbl++;
            if (write0) gcnt[num_write0_out]++;
            if (write1) gcnt[num_write1_out]++;
        end
        src_valid = '0;
        chk("stream_double_writes", 32'(dbl), 32'd100);
        for (int i = 0; i < N; i++) chk($sformatf("stream_grants_src%0d", i), 32'(gcnt[i]), 32'd50);
        repeat (3) tick();

        // back-to-back on one source
        do_reset();
        set_src(2, 3'd6, 16'h2000);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("b2b_ready2", 32'(src_ready[2]), 32'h1);
            if (j > 0) begin
                chk("b2b_data0",  32'(data_write0_out), 32'(16'h2000 + j - 1));
                chk("b2b_write1", 32'(write1), 32'h0);
            end
            tick();
            if (j == 9) src_valid = '0;
            else src_data[2*16 +: 16] = 16'(16'h2000 + j + 1);
        end
        @(negedge clk);
        chk("b2b_last_data0", 32'(data_write0_out), 32'h2009);
        tick();
        @(negedge clk);
        chk("b2b_drained", 32'(write0), 32'h0);

        // reset with slots pending
        do_reset();
        set_src(0, 3'd4, 16'hC000);
        set_src(1, 3'd4, 16'hC001);
        set_src(2, 3'd4, 16'hC002);
        tick();
        src_valid = '0;
        #1;
        chk("rstmid_pre_write0", 32'(write0), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstmid_write0", 32'(write0), 32'h0);
        chk("rstmid_write1", 32'(write1), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(src_ready), 32'hF);
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            if (write0 || write1) stale++;
            @(negedge clk);
        end
        chk("rstmid_stale_writes", 32'(stale), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: NSRC, 4, number of result sources (legal 2..8).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: src_valid  input  NSRC  per-source result valid.
REQ-005 SHALL have port: src_ready  output  NSRC  per-source accept.
REQ-006 SHALL have port: src_dest  input  NSRC*3  per-source destination register, source i at bits [3i+2:3i].
REQ-007 SHALL have port: src_data  input  NSRC*16  per-source result data, source i at bits [16i+15:16i].
REQ-008 SHALL have ports: write0 / num_write0_out / data_write0_out  output  1/3/16  register-file write port 0.
REQ-009 SHALL have ports: write1 / num_write1_out / data_write1_out  output  1/3/16  register-file write port 1.
REQ-010 SHALL have port: wr_done  output  8  one bit per register, pulses one cycle after that register is written.

Function
REQ-011 SHALL hold one slot per source: full flag, 3-bit dest, 16-bit data.
REQ-012 SHALL accept source i at an edge where src_valid[i] && src_ready[i]; slot i loads and is full next cycle.
REQ-013 SHALL drive src_ready[i] = !full[i] || granted[i]; it SHALL NOT depend combinationally on any src_valid, src_dest or src_data.
REQ-014 SHALL choose grant A combinationally: the first full slot at or after rr_ptr, in modulo-NSRC order.
REQ-015 SHALL choose grant B: the next full slot after A in the same order whose dest != A.dest; none if no such slot exists.
REQ-016 SHALL drive write0 from A and write1 from B in the same cycle; with no grant, write0/write1 = 0 and num/data outputs = 0.
REQ-017 SHALL never assert write0 and write1 together with num_write0_out == num_write1_out.
REQ-018 SHALL clear a granted slot at the next edge unless the same edge accepts a new result into it (accept wins; slot stays full).
REQ-019 SHALL advance rr_ptr at each edge to (index of last grant + 1) mod NSRC; with no grant, rr_ptr SHALL hold.
REQ-020 SHALL give zero-bubble latency: accept at edge k -> write asserted in cycle k+1 -> register file commits at edge k+2.
REQ-021 SHALL sustain one result per cycle per source while it is granted every cycle; two writes per cycle in total.
REQ-022 SHALL preserve per-source order; order across sources is the scheduler's responsibility.
REQ-023 SHALL register wr_done <= onehot(num_write0_out)&write0 | onehot(num_write1_out)&write1 each edge.
REQ-024 SHALL defer a same-dest loser to a later cycle without dropping it; round-robin order SHALL guarantee it a grant within NSRC cycles.

Reset
REQ-025 SHALL, on rst, clear all full flags, rr_ptr = 0 and wr_done = 0, asynchronously.
REQ-026 SHALL drop results pending in slots when rst asserts mid-operation; src_ready = all-ones from the first cycle after rst deasserts.
REQ-027 SHALL hold write0 = write1 = 0 while rst is high.

Structure
REQ-028 SHALL take REG_W=16, REG_AW=3, NREGS=8 and typedef wb_req_t {dest, data} from shared package wb_pkg.
REQ-029 SHALL place grant logic in one combinational sub-module, rr_pick2: inputs full mask, dest vector, rr_ptr; outputs A/B indices and valids.

Verification
REQ-030 SHALL cover: single result, src0 dest 3 data 0xBEEF accepted at edge 1 -> write0=1, num=3, data=0xBEEF in cycle 2; wr_done=0x08 in cycle 3.
REQ-031 SHALL cover: src0 dest 1, src1 dest 2 accepted together -> write0 to r1 and write1 to r2 in the same cycle; wr_done=0x06 next cycle.
REQ-032 SHALL cover: src0 and src1 both dest 5, rr_ptr=0 -> src0 written first, src1 written the following cycle; write1 never targets r5 alongside write0.
REQ-033 SHALL cover: all 4 sources valid every cycle, distinct dests -> 2 writes/cycle, each source granted once per 2 cycles, no starvation over 100 cycles.
REQ-034 SHALL cover: src2 back-to-back 10 results, others idle -> src_ready[2] stays 1, one write per cycle, in order.
REQ-035 SHALL cover: rst asserted with 3 slots full -> write0/write1 = 0 immediately, src_ready = 0xF after release, no stale writes.
